// File: rtl/uart_frame_arbiter_if.sv
`default_nettype none
// =====================================================================
// Module : uart_frame_arbiter_if
// Desc   : Channel-FIFO and uart_tx signals seen by the frame arbiter.
//          Names carry the arbiter's direction (_i into it, _o out).
// Rev    : 1.0  initial release
// =====================================================================
interface uart_frame_arbiter_if #(
  parameter int NCH = 4,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0]   fifo_empty_i;
  logic [8*NCH-1:0] fifo_data_i;
  logic [NCH-1:0]   fifo_rd_o;
  logic             tx_ready_i;
  logic             tx_done_i;
  logic             tx_start_o;
  logic [7:0]       tx_data_o;
  logic             busy_o;
  logic [CW-1:0]    cur_ch_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, tx_ready_i, tx_done_i,
    output fifo_rd_o, tx_start_o, tx_data_o, busy_o, cur_ch_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, tx_ready_i, tx_done_i,
    input  fifo_rd_o, tx_start_o, tx_data_o, busy_o, cur_ch_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_frame_arbiter.sv
`default_nettype none
// =====================================================================
// Module : uart_frame_arbiter
// Desc   : Round-robin packer of NCH byte FIFOs into framed packets
//          (SYNC, id, len, payload, csum) for a single uart_tx.
// Rev    : 1.0  initial release
// =====================================================================
module uart_frame_arbiter #(
  parameter int         NCH   = 4,
  parameter int         BURST = 8,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_frame_arbiter_if.master bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_RD_ISSUE = 3'd1;
  localparam logic [2:0] c_RD_CAP   = 3'd2;
  localparam logic [2:0] c_TX_LOAD  = 3'd3;
  localparam logic [2:0] c_TX_START = 3'd4;
  localparam logic [2:0] c_TX_WAIT  = 3'd5;

  logic [2:0]     state_q,    state_d;
  logic [CW-1:0]  last_ch_q,  last_ch_d;
  logic [CW-1:0]  cur_ch_q,   cur_ch_d;
  logic           busy_q,     busy_d;
  logic [3:0]     len_q,      len_d;
  logic [4:0]     idx_q,      idx_d;
  logic [7:0]     csum_q,     csum_d;
  logic [7:0]     buf_q [BURST];
  logic [7:0]     buf_d [BURST];
  logic [NCH-1:0] fifo_rd_q,  fifo_rd_d;
  logic           tx_start_q, tx_start_d;
  logic [7:0]     tx_data_q,  tx_data_d;

  logic           w_any;
  logic           w_hi_any;
  logic [CW-1:0]  w_hi_ch;
  logic [CW-1:0]  w_lo_ch;
  logic [CW-1:0]  w_pick_ch;
  logic           w_cur_empty;
  logic [7:0]     w_cur_data;
  logic [7:0]     w_payload;
  logic [7:0]     w_frame_byte;
  logic [4:0]     w_last_idx;

  assign w_any = ~&bus.fifo_empty_i;

  // Round-robin: lowest non-empty channel above last_ch, else lowest overall.
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_ch  = '0;
    w_lo_ch  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (!bus.fifo_empty_i[k]) begin
        w_lo_ch = CW'(k);
        if (CW'(k) > last_ch_q) begin
          w_hi_ch  = CW'(k);
          w_hi_any = 1'b1;
        end
      end
    end
    w_pick_ch = w_hi_any ? w_hi_ch : w_lo_ch;
  end

  always_comb begin
    w_cur_empty = 1'b1;
    w_cur_data  = 8'h00;
    for (int k = 0; k < NCH; k++) begin
      if (cur_ch_q == CW'(k)) begin
        w_cur_empty = bus.fifo_empty_i[k];
        w_cur_data  = bus.fifo_data_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_payload = 8'h00;
    for (int k = 0; k < BURST; k++) begin
      if (idx_q == 5'(k + 3)) begin
        w_payload = buf_q[k];
      end
    end
  end

  // Frame index of the checksum byte; everything in 3..w_last_idx-1 is payload.
  assign w_last_idx = {1'b0, len_q} + 5'd3;

  always_comb begin
    if (idx_q == 5'd0) begin
      w_frame_byte = SYNC;
    end else if (idx_q == 5'd1) begin
      w_frame_byte = {{(8-CW){1'b0}}, cur_ch_q};
    end else if (idx_q == 5'd2) begin
      w_frame_byte = {4'b0000, len_q};
    end else if (idx_q < w_last_idx) begin
      w_frame_byte = w_payload;
    end else begin
      w_frame_byte = csum_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_ch_d  = last_ch_q;
    cur_ch_d   = cur_ch_q;
    busy_d     = busy_q;
    len_d      = len_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    buf_d      = buf_q;
    fifo_rd_d  = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;

    case (state_q)
      c_IDLE: begin
        if (w_any) begin
          cur_ch_d = w_pick_ch;
          busy_d   = 1'b1;
          len_d    = 4'd0;
          idx_d    = 5'd0;
          csum_d   = {{(8-CW){1'b0}}, w_pick_ch};
          state_d  = c_RD_ISSUE;
        end else begin
          busy_d   = 1'b0;
        end
      end

      c_RD_ISSUE: begin
        if (!w_cur_empty && (len_q < 4'(BURST))) begin
          for (int k = 0; k < NCH; k++) begin
            fifo_rd_d[k] = (cur_ch_q == CW'(k));
          end
          state_d = c_RD_CAP;
        end else begin
          // Payload complete (burst full or FIFO ran dry): fold len into csum.
          csum_d  = csum_q + {4'b0000, len_q};
          state_d = c_TX_LOAD;
        end
      end

      c_RD_CAP: begin
        for (int k = 0; k < BURST; k++) begin
          if (len_q == 4'(k)) begin
            buf_d[k] = w_cur_data;
          end
        end
        csum_d  = csum_q + w_cur_data;
        len_d   = len_q + 4'd1;
        state_d = c_RD_ISSUE;
      end

      c_TX_LOAD: begin
        tx_data_d = w_frame_byte;
        state_d   = c_TX_START;
      end

      c_TX_START: begin
        if (bus.tx_ready_i) begin
          tx_start_d = 1'b1;
          state_d    = c_TX_WAIT;
        end
      end

      c_TX_WAIT: begin
        if (bus.tx_done_i) begin
          if (idx_q < w_last_idx) begin
            idx_d   = idx_q + 5'd1;
            state_d = c_TX_LOAD;
          end else begin
            last_ch_d = cur_ch_q;
            busy_d    = 1'b0;
            state_d   = c_IDLE;
          end
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= c_IDLE;
      last_ch_q  <= CW'(NCH - 1);
      cur_ch_q   <= '0;
      busy_q     <= 1'b0;
      len_q      <= 4'd0;
      idx_q      <= 5'd0;
      csum_q     <= 8'h00;
      fifo_rd_q  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      for (int k = 0; k < BURST; k++) begin
        buf_q[k] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      last_ch_q  <= last_ch_d;
      cur_ch_q   <= cur_ch_d;
      busy_q     <= busy_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      fifo_rd_q  <= fifo_rd_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      for (int k = 0; k < BURST; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

  assign bus.fifo_rd_o  = fifo_rd_q;
  assign bus.tx_start_o = tx_start_q;
  assign bus.tx_data_o  = tx_data_q;
  assign bus.busy_o     = busy_q;
  assign bus.cur_ch_o   = cur_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_arbiter.sv
`default_nettype none
// =====================================================================
// Module : tb_uart_frame_arbiter
// Desc   : Scoreboard bench: FIFO/uart_tx models plus a frame-level
//          reference model predicting every transmitted byte.
// Rev    : 1.0  initial release
// =====================================================================
module tb_uart_frame_arbiter;
  localparam int         NCH   = 4;
  localparam int         BURST = 8;
  localparam logic [7:0] SYNC  = 8'hA5;
  localparam int         DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_arbiter_if #(.NCH(NCH)) bus ();

  uart_frame_arbiter #(.NCH(NCH), .BURST(BURST), .SYNC(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] b;
    int         ch;
    int         pos;
  } item_t;

  item_t      exp_q[$];
  logic [7:0] fmem [NCH][DEPTH];
  int         fwr  [NCH];
  int         frd  [NCH];
  int         m_rd [NCH];
  int         m_last;

  int n_checks = 0;
  int n_fail   = 0;

  // uart_tx model knobs and monitor state
  int         done_min = 1, done_max = 4, hold_min = 0, hold_max = 2;
  int         u_cnt = 0, u_hold = 0, gap = 0, rd_in_frame = 0;
  bit         in_flight = 0, changed = 0, prev_busy = 0, gap_more = 0, gap_reset = 1;
  bit         arm_rst = 0, rst_trig = 0;
  logic [7:0] held = 8'h00;
  logic [NCH-1:0] pend_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input int ch, input logic [7:0] v);
    fmem[ch][fwr[ch]] = v;
    fwr[ch]++;
  endtask

  function automatic bit fifo_pending();
    bit p = 1'b0;
    for (int k = 0; k < NCH; k++) if (fwr[k] != frd[k]) p = 1'b1;
    return p;
  endfunction

  // Reference model: frames that drain the loaded FIFO contents in round-robin order.
  task automatic predict();
    int         ch, n;
    bit         found;
    logic [7:0] cs, v;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      ch    = 0;
      for (int k = 1; k <= NCH; k++) begin
        if (!found && fwr[(m_last + k) % NCH] > m_rd[(m_last + k) % NCH]) begin
          ch    = (m_last + k) % NCH;
          found = 1'b1;
        end
      end
      if (found) begin
        n  = fwr[ch] - m_rd[ch];
        if (n > BURST) n = BURST;
        cs = 8'(ch + n);
        exp_q.push_back('{SYNC, ch, 0});
        exp_q.push_back('{8'(ch), ch, 1});
        exp_q.push_back('{8'(n), ch, 2});
        for (int i = 0; i < n; i++) begin
          v = fmem[ch][m_rd[ch]];
          m_rd[ch]++;
          cs = cs + v;
          exp_q.push_back('{v, ch, 3 + i});
        end
        exp_q.push_back('{cs, ch, 3 + n});
        m_last = ch;
      end
    end
  endtask

  task automatic wait_quiet(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || bus.busy_o !== 1'b0 || in_flight || fifo_pending()) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_within_budget", 32'(t < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_fifo_rd",  bus.fifo_rd_o,  0);
    chk("rst_tx_start", bus.tx_start_o, 0);
    chk("rst_tx_data",  bus.tx_data_o,  0);
    chk("rst_busy",     bus.busy_o,     0);
    chk("rst_cur_ch",   bus.cur_ch_o,   0);
  endtask

  // Monitor, FIFO model and uart_tx model, all sampled mid-cycle.
  always @(negedge clk) begin
    item_t          e;
    logic [NCH-1:0] rd;
    if (rst) begin
      pend_rd          = '0;
      in_flight        = 1'b0;
      u_cnt            = 0;
      prev_busy        = 1'b0;
      gap_reset        = 1'b1;
      rd_in_frame      = 0;
      bus.tx_done_i    = 1'b0;
      bus.tx_ready_i   = 1'b1;
    end else begin
      rd = bus.fifo_rd_o;
      if (rd != '0) begin
        chk("fifo_rd_onehot", 32'($onehot(rd)), 1);
        for (int k = 0; k < NCH; k++) begin
          if (rd[k]) begin
            chk("fifo_rd_on_nonempty", bus.fifo_empty_i[k], 0);
            if (exp_q.size() != 0) chk("fifo_rd_channel", k, exp_q[0].ch);
          end
        end
        rd_in_frame++;
      end

      if (!bus.busy_o) begin
        if (prev_busy) begin
          gap      = 0;
          gap_more = (exp_q.size() != 0);
        end
        gap++;
      end else if (!prev_busy) begin
        if (gap_more && !gap_reset) chk("idle_gap_cycles", gap, 1);
        gap_reset   = 1'b0;
        gap_more    = 1'b0;
        rd_in_frame = 0;
      end
      prev_busy = bus.busy_o;

      if (bus.tx_start_o) begin
        chk("tx_ready_at_start", bus.tx_ready_i, 1);
        chk("start_while_in_flight", 32'(in_flight), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_tx_start: got byte 0x%02h, expected no byte (t=%0t)", bus.tx_data_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", bus.tx_data_o, e.b);
          chk("cur_ch", bus.cur_ch_o, e.ch);
          if (e.pos == 2) chk("reads_in_frame", rd_in_frame, e.b);
          if (arm_rst && e.ch == 1 && e.pos == 6) rst_trig = 1'b1;
        end
        in_flight = 1'b1;
        changed   = 1'b0;
        held      = bus.tx_data_o;
        u_cnt     = $urandom_range(done_max, done_min);
      end

      bus.tx_done_i = 1'b0;
      if (in_flight && !bus.tx_start_o) begin
        if (bus.tx_data_o !== held) changed = 1'b1;
        u_cnt--;
        if (u_cnt <= 0) begin
          bus.tx_done_i = 1'b1;
          in_flight     = 1'b0;
          chk("tx_data_stable", 32'(changed), 0);
          u_hold = $urandom_range(hold_max, hold_min);
        end
      end
      bus.tx_ready_i = !in_flight && (u_hold == 0);
      if (u_hold > 0 && !in_flight) u_hold--;

      // A strobe seen this cycle is consumed at the next edge; the pop shows here.
      for (int k = 0; k < NCH; k++) begin
        if (pend_rd[k] && frd[k] < fwr[k]) frd[k]++;
      end
      pend_rd = rd;
    end

    for (int k = 0; k < NCH; k++) begin
      bus.fifo_empty_i[k]       = (fwr[k] == frd[k]);
      bus.fifo_data_i[8*k +: 8] = (fwr[k] == frd[k]) ? 8'h00 : fmem[k][frd[k]];
    end
  end

  initial begin
    int t;
    int n;
    m_last = NCH - 1;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    // Ch2 holds 01..08: one full burst.
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push_byte(2, 8'(i));
    predict();
    wait_quiet(3000);

    // Ch0 runs dry after three bytes.
    push_byte(0, 8'h10); push_byte(0, 8'h20); push_byte(0, 8'h30);
    predict();
    wait_quiet(3000);

    // Ch3 eight 0xFF: checksum wrap.
    for (int i = 0; i < 8; i++) push_byte(3, 8'hFF);
    predict();
    wait_quiet(3000);

    // All channels loaded at once: back-to-back round-robin frames.
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 16; i++) push_byte(c, 8'($urandom));
    predict();
    wait_quiet(6000);

    // Slow transmitter: ready held low 50 cycles, 100-cycle shift per byte.
    done_min = 100; done_max = 100; hold_min = 50; hold_max = 50;
    u_hold = 50;
    for (int i = 0; i < 3; i++) push_byte(0, 8'($urandom));
    predict();
    wait_quiet(4000);
    done_min = 1; done_max = 4; hold_min = 0; hold_max = 2;
    u_hold = 0;

    // Random channel subsets and lengths.
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < NCH; c++) begin
        if (c == r % NCH || $urandom_range(1, 0) == 1) begin
          n = $urandom_range(20, 1);
          for (int i = 0; i < n; i++) push_byte(c, 8'($urandom));
        end
      end
      predict();
      wait_quiet(6000);
    end

    // Reset during payload byte 4 of a ch1 frame.
    done_min = 10; done_max = 10;
    arm_rst  = 1'b1;
    rst_trig = 1'b0;
    for (int i = 0; i < 12; i++) push_byte(1, 8'($urandom));
    predict();
    t = 0;
    while (!rst_trig && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("reset_point_reached", 32'(rst_trig), 1);
    arm_rst = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    exp_q.delete();
    m_last = NCH - 1;
    for (int k = 0; k < NCH; k++) m_rd[k] = frd[k];
    for (int i = 0; i < 5; i++) push_byte(0, 8'($urandom));
    predict();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    done_min = 1; done_max = 4;
    wait_quiet(4000);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
